// File: rtl/row_hq_serializer_pkg.sv
// Shared constants, state encoding and beat-to-row mapping for the row-H serializer.
package row_hq_serializer_pkg;

    localparam int unsigned CHUNK_W = 16;
    localparam int unsigned NROWS   = 4;
    localparam int unsigned NBEATS  = 2 * NROWS;
    localparam int unsigned ROW_W   = 2 * CHUNK_W;
    localparam int unsigned CNT_W   = 3;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Two beats per row: beat k carries row k>>1, high half on even k.
    function automatic logic [1:0] beat_row(input logic [CNT_W-1:0] k);
        return k[CNT_W-1:1];
    endfunction

    function automatic logic beat_is_hi(input logic [CNT_W-1:0] k);
        return ~k[0];
    endfunction

endpackage

// File: rtl/row_hq_serializer_lane.sv
// One serial lane: captures four rows and presents one registered 16-bit beat per advance.
module row_lane_ser
    import row_hq_serializer_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            capture,
    input  logic                            advance,
    input  logic                            clear,
    input  logic [CNT_W-1:0]                next_beat,
    input  logic [NROWS-1:0][ROW_W-1:0]     rows,
    output logic [CHUNK_W-1:0]              beat
);

    logic [NROWS-1:0][ROW_W-1:0] cap;
    logic [ROW_W-1:0]            sel_row;

    always_comb begin
        sel_row = cap[beat_row(next_beat)];
    end

    // Beat 0 comes straight from the inputs since the capture registers load on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap  <= '0;
            beat <= '0;
        end else if (capture) begin
            cap  <= rows;
            beat <= rows[0][ROW_W-1:CHUNK_W];
        end else if (advance) begin
            beat <= beat_is_hi(next_beat) ? sel_row[ROW_W-1:CHUNK_W] : sel_row[CHUNK_W-1:0];
        end else if (clear) begin
            beat <= '0;
        end
    end

endmodule

// File: rtl/row_hq_serializer.sv
// Row-H link transmitter: eight 16-bit beats per burst on parallel real/imag lanes.
// Optional backpressure via macro ROW_HQ_SERIALIZER_STALL_EN (adds sink_ready).
module row_hq_serializer
    import row_hq_serializer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef ROW_HQ_SERIALIZER_STALL_EN
    input  logic                sink_ready,
`endif
    input  logic [ROW_W-1:0]    in_rowHr0,
    input  logic [ROW_W-1:0]    in_rowHr1,
    input  logic [ROW_W-1:0]    in_rowHr2,
    input  logic [ROW_W-1:0]    in_rowHr3,
    input  logic [ROW_W-1:0]    in_rowHi0,
    input  logic [ROW_W-1:0]    in_rowHi1,
    input  logic [ROW_W-1:0]    in_rowHi2,
    input  logic [ROW_W-1:0]    in_rowHi3,
    output logic [CHUNK_W-1:0]  sdr,
    output logic [CHUNK_W-1:0]  sdi,
    output logic                sd_valid,
    output logic                sd_start,
    output logic                busy,
    output logic                finish
);

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           next_cnt;
    logic                       accept;
    logic                       capture;
    logic                       advance;
    logic                       clear;
    logic [NROWS-1:0][ROW_W-1:0] hr_rows;
    logic [NROWS-1:0][ROW_W-1:0] hi_rows;

`ifdef ROW_HQ_SERIALIZER_STALL_EN
    assign accept = sink_ready;
`else
    assign accept = 1'b1;
`endif

    assign next_cnt = cnt + CNT_W'(1);
    assign hr_rows  = {in_rowHr3, in_rowHr2, in_rowHr1, in_rowHr0};
    assign hi_rows  = {in_rowHi3, in_rowHi2, in_rowHi1, in_rowHi0};

    always_comb begin
        capture = (state == IDLE) && start;
        advance = (state == SEND) && accept && (cnt != LAST_BEAT);
        clear   = (state == SEND) && accept && (cnt == LAST_BEAT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sd_valid <= 1'b0;
            sd_start <= 1'b0;
            busy     <= 1'b0;
            finish   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    finish <= 1'b0;
                    if (start) begin
                        state    <= SEND;
                        cnt      <= '0;
                        sd_valid <= 1'b1;
                        sd_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept) begin
                        sd_start <= 1'b0;
                        if (cnt == LAST_BEAT) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            sd_valid <= 1'b0;
                            busy     <= 1'b0;
                            finish   <= 1'b1;
                        end else begin
                            cnt <= next_cnt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    row_lane_ser u_lane_r (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .advance   (advance),
        .clear     (clear),
        .next_beat (next_cnt),
        .rows      (hr_rows),
        .beat      (sdr)
    );

    row_lane_ser u_lane_i (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .advance   (advance),
        .clear     (clear),
        .next_beat (next_cnt),
        .rows      (hi_rows),
        .beat      (sdi)
    );

endmodule
